// File: rtl/dbus_xbar_reg.sv
// Registered CPU data-bus decoder: latches one master request, drives a single decoded slave,
// and returns registered read data, turning unmapped or timed-out accesses into a bus error.
module dbus_xbar_reg #(
   parameter int unsigned          NSLAVE   = 6,
   parameter logic [NSLAVE*32-1:0] SLV_BASE = {32'h1FD00500, 32'h1FD00400, 32'h1FD003F0,
                                               32'h1B000000, 32'h1E000000, 32'h00000000},
   parameter logic [NSLAVE*32-1:0] SLV_MASK = {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFFF0,
                                               32'hFF000000, 32'hFF000000, 32'hFF000000},
   parameter int unsigned          TIMEOUT  = 256,
   parameter logic [31:0]          ERR_DATA = 32'hDEADBEEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            master_address,
   input  logic [3:0]             master_byteenable,
   input  logic                   master_read,
   input  logic                   master_write,
   input  logic [31:0]            master_wrdata,
   output logic [31:0]            master_rddata,
   output logic                   master_stall,
   output logic [31:0]            slv_address,
   output logic [31:0]            slv_wrdata,
   output logic [3:0]             slv_byteenable,
   output logic [NSLAVE-1:0]      slv_rd,
   output logic [NSLAVE-1:0]      slv_wr,
   input  logic [NSLAVE*32-1:0]   slv_rddata,
   input  logic [NSLAVE-1:0]      slv_stall,
   output logic                   bus_error,
   output logic [31:0]            err_address,
   input  logic                   err_clr
);

   localparam int unsigned IdxW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       slv_addr_q, slv_addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              wr_q, wr_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              bus_err_q, bus_err_d;
   logic [31:0]       err_addr_q, err_addr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic              dec_hit;
   logic [IdxW-1:0]   dec_idx;
   logic [31:0]       dec_mask;
   logic              err_set;
   logic [NSLAVE-1:0] sel_onehot;
   logic [31:0]       sel_rddata;

   // Scan downwards so the lowest matching index wins.
   always_comb begin
      dec_hit  = 1'b0;
      dec_idx  = '0;
      dec_mask = SLV_MASK[31:0];
      for (int i = int'(NSLAVE) - 1; i >= 0; i--) begin
         if ((master_address & SLV_MASK[i*32 +: 32]) ==
             (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
            dec_hit  = 1'b1;
            dec_idx  = IdxW'(i);
            dec_mask = SLV_MASK[i*32 +: 32];
         end
      end
   end

   always_comb begin
      sel_onehot = NSLAVE'(1) << idx_q;
      sel_rddata = slv_rddata[32*int'(idx_q) +: 32];
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      slv_addr_d = slv_addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      wr_d       = wr_q;
      idx_d      = idx_q;
      rdata_d    = rdata_q;
      err_addr_d = err_addr_q;
      cnt_d      = cnt_q;
      err_set    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (master_read || master_write) begin
               addr_d     = master_address;
               slv_addr_d = master_address & ~dec_mask;
               wdata_d    = master_wrdata;
               be_d       = master_byteenable;
               wr_d       = master_write;
               idx_d      = dec_idx;
               cnt_d      = '0;
               if (dec_hit) begin
                  state_d = StAccess;
               end else begin
                  err_set    = 1'b1;
                  err_addr_d = master_address;
                  rdata_d    = master_write ? 32'h0 : ERR_DATA;
                  state_d    = StResp;
               end
            end
         end
         StAccess: begin
            cnt_d = cnt_q + CntW'(1);
            if (!slv_stall[idx_q]) begin
               rdata_d = wr_q ? 32'h0 : sel_rddata;
               state_d = StResp;
            end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
               err_set    = 1'b1;
               err_addr_d = addr_q;
               rdata_d    = wr_q ? 32'h0 : ERR_DATA;
               state_d    = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: state_d = StIdle;
      endcase
      // A new error outranks a simultaneous clear.
      bus_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : bus_err_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         slv_addr_q <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         wr_q       <= 1'b0;
         idx_q      <= '0;
         rdata_q    <= '0;
         bus_err_q  <= 1'b0;
         err_addr_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         slv_addr_q <= slv_addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         wr_q       <= wr_d;
         idx_q      <= idx_d;
         rdata_q    <= rdata_d;
         bus_err_q  <= bus_err_d;
         err_addr_q <= err_addr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      slv_rd       = '0;
      slv_wr       = '0;
      master_stall = 1'b0;
      unique case (state_q)
         StIdle:   master_stall = master_read | master_write;
         StAccess: begin
            master_stall = 1'b1;
            if (wr_q) slv_wr = sel_onehot;
            else      slv_rd = sel_onehot;
         end
         default:  master_stall = 1'b0;
      endcase
   end

   assign master_rddata  = rdata_q;
   assign slv_address    = slv_addr_q;
   assign slv_wrdata     = wdata_q;
   assign slv_byteenable = be_q;
   assign bus_error      = bus_err_q;
   assign err_address    = err_addr_q;

endmodule
